melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Programmable melody player: a small sequence RAM holds note words; a FSM fetches each word and drives a square-wave tone generator for the word's duration.
- Successor to the fixed-tune music box. Generalised over clock frequency, sequence depth and tempo.
- Adds rests, per-note duration, optional inter-note gap, start/stop control, one-shot or loop mode and a runtime-writable tune.
- Sits between a host/config register block and the speaker output pin.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz; used to derive tone half-periods at elaboration.
- TICK_CYCLES, 12000, clock cycles per duration unit.
- SEQ_AW, 5, sequence address width; depth is 2**SEQ_AW words.
- DUR_W, 3, duration field width; a note lasts (dur+1)*TICK_CYCLES cycles.
- GAP_CYCLES, 0, silent cycles at the end of every note, for articulation; must be < TICK_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  sequence RAM write strobe.
- wr_addr  in  SEQ_AW  write address.
- wr_data  in  4+DUR_W  note word: {pitch[3:0], dur[DUR_W-1:0]}.
- seq_len  in  SEQ_AW+1  number of valid words, 1..2**SEQ_AW; sampled on start.
- loop_en  in  1  1 = wrap to word 0 after the last word; sampled at each end-of-sequence.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- speaker  out  1  registered square wave.
- busy  out  1  high while not IDLE.
- note_idx  out  SEQ_AW  index of the word currently playing.
- done  out  1  one-cycle pulse when a one-shot sequence finishes.

Behaviour:
- Clocking and reset: one clock. Asynchronous active-low reset.
- Outputs in reset: speaker=0, busy=0, note_idx=0, done=0, FSM=IDLE, all counters 0. RAM contents are not reset.
- Pitch codes:
  - 0 = rest.
  - 1..13 = C4, C#4, D4, D#4, E4, F4, F#4, G4, G#4, A4, A#4, B4, C5 (262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523 Hz).
  - 14..15 = rest.
- Half-period per code: HP = CLK_HZ/(2*f), integer-truncated, computed at elaboration. HP ≥ 2 is required (elaboration assertion).
- RAM: synchronous write; registered read with 1-cycle latency and read-first behaviour. A same-cycle write and fetch to the same address returns the old word.
- Writes are accepted in any state. A word rewritten during play takes effect when that word is next fetched.
- FSM states:
  - IDLE: on start with seq_len != 0, latch seq_len, set idx=0, go to FETCH, busy=1. start with seq_len==0 is ignored.
  - FETCH (1 cycle): RAM read of idx. Next cycle latch pitch and dur; clear tone counter, duration counter and speaker; go to PLAY.
  - PLAY: duration counter runs 0..(dur+1)*TICK_CYCLES-1.
    - Tone counter runs 0..HP-1; speaker toggles at the wrap.
    - Speaker is forced 0 for rest codes and for the final GAP_CYCLES of the note.
    - At the last count, if idx < len-1: idx+1, go to FETCH.
    - Else if loop_en: idx=0, go to FETCH.
    - Else: go to IDLE, done=1 for one cycle, speaker=0.
- Inter-note overhead: exactly 1 FETCH cycle, during which speaker holds 0.
- Stop: in any non-IDLE state, go to IDLE on the next edge with speaker=0 and note_idx=0, no done pulse. stop has priority over start and over end-of-note in the same cycle.
- start while busy is ignored.
- Counter widths are derived from the parameters. Duration product width is clog2((2**DUR_W)*TICK_CYCLES). No overflow is permitted.
- Asserting reset mid-note forces all reset values immediately.

Decomposition:
- Package melody_pkg holds:
  - pitch code constants (P_REST, P_C4 .. P_C5),
  - the frequency table,
  - a constant function computing half-periods from CLK_HZ,
  - the note word field positions,
  - the FSM state enum.
- Sub-module tone_gen: half-period input, enable, clear → square wave. Reused by later multi-voice blocks.

Test Plan:
- Bench uses CLK_HZ=26400, TICK_CYCLES=200, GAP_CYCLES=0 (A4 HP=30, C5 HP=25).
- Single note: RAM[0]={A4, dur=1}, seq_len=1, loop_en=0, start → speaker toggles every 30 cycles for 400 cycles; done pulses once; busy falls on the same edge.
- Rest plus sequence: words {C5,0}, {rest,0}, {A4,0} → 200 cycles at HP 25, 200 cycles speaker=0, 200 cycles at HP 30; note_idx steps 0,1,2 with a 1-cycle FETCH between notes.
- Loop: same tune, loop_en=1 → after idx 2, note_idx returns to 0 and there is no done; clear loop_en during word 1 → stops after word 2 with done.
- Stop mid-note: stop at cycle 100 of word 0 → next edge busy=0, speaker=0, note_idx=0, no done; a simultaneous start is ignored.
- Gap: GAP_CYCLES=50, word {A4,0} → speaker active for 150 cycles, then 0 for 50 cycles.
- Reset and live write: assert rst_n low mid-PLAY → outputs zero asynchronously. Separately, rewrite word 1 while word 0 plays → the new pitch is heard.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module      : melody_pkg
// Description : Shared definitions for the melody sequencer family. Contains
//               pitch codes, the note frequency table, the half-period helper,
//               the note word layout and the sequencer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package melody_pkg;

  // Note word layout: {pitch[PITCH_W-1:0], dur[DUR_W-1:0]}. The duration
  // field sits in the LSBs, and the pitch field sits immediately above it.
  localparam int PITCH_W = 4;

  // Pitch codes. Codes 14 and 15 are also treated as rests.
  localparam logic [3:0] P_REST = 4'd0;
  localparam logic [3:0] P_C4   = 4'd1;
  localparam logic [3:0] P_CS4  = 4'd2;
  localparam logic [3:0] P_D4   = 4'd3;
  localparam logic [3:0] P_DS4  = 4'd4;
  localparam logic [3:0] P_E4   = 4'd5;
  localparam logic [3:0] P_F4   = 4'd6;
  localparam logic [3:0] P_FS4  = 4'd7;
  localparam logic [3:0] P_G4   = 4'd8;
  localparam logic [3:0] P_GS4  = 4'd9;
  localparam logic [3:0] P_A4   = 4'd10;
  localparam logic [3:0] P_AS4  = 4'd11;
  localparam logic [3:0] P_B4   = 4'd12;
  localparam logic [3:0] P_C5   = 4'd13;

  // Frequency table in Hz; 0 marks a rest code.
  function automatic int note_freq_hz(input logic [3:0] code);
    case (code)
      P_REST:  return 0;
      P_C4:    return 262;
      P_CS4:   return 277;
      P_D4:    return 294;
      P_DS4:   return 311;
      P_E4:    return 330;
      P_F4:    return 349;
      P_FS4:   return 370;
      P_G4:    return 392;
      P_GS4:   return 415;
      P_A4:    return 440;
      P_AS4:   return 466;
      P_B4:    return 494;
      P_C5:    return 523;
      default: return 0;
    endcase
  endfunction

  // Tone half-period in clock cycles (truncated); 0 for rests.
  function automatic int half_period(input int clk_hz, input logic [3:0] code);
    int f;
    f = note_freq_hz(code);
    if (f == 0) return 0;
    return clk_hz / (2 * f);
  endfunction

  function automatic logic is_rest(input logic [3:0] code);
    return (note_freq_hz(code) == 0);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_gen
// Description : Square-wave tone generator. Counts 0..half_period-1 while
//               enabled and toggles the output at each wrap. clr has priority
//               and returns both the counter and the output to 0.
// Ports       : clk, rst_n (async, active-low), en, clr,
//               half_period[HP_W-1:0] (must be >= 2 when enabled),
//               wave (registered square wave)
// Revision    : 1.0 - initial release
// ============================================================================
module tone_gen #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en) begin
      if (cnt == half_period - HP_W'(1)) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Programmable melody player. A sequence RAM holds note words
//               {pitch, dur}; an FSM fetches each word and drives a tone
//               generator for (dur+1)*TICK_CYCLES cycles, with optional
//               silent articulation gap, one-shot or loop playback and stop.
// Ports       : clk, rst_n (async, active-low)
//               wr_en/wr_addr/wr_data : sequence RAM write port
//               seq_len  : number of valid words, sampled on start
//               loop_en  : wrap to word 0 at end of sequence
//               start/stop : single-cycle control requests
//               speaker  : registered square wave
//               busy     : high while not idle
//               note_idx : index of the word currently playing
//               done     : one-cycle pulse at end of a one-shot sequence
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int TICK_CYCLES = 12000,
  parameter int SEQ_AW      = 5,
  parameter int DUR_W       = 3,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [SEQ_AW-1:0]        wr_addr,
  input  logic [PITCH_W+DUR_W-1:0] wr_data,
  input  logic [SEQ_AW:0]          seq_len,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic                     speaker,
  output logic                     busy,
  output logic [SEQ_AW-1:0]        note_idx,
  output logic                     done
);

  localparam int WORD_W = PITCH_W + DUR_W;
  localparam int DEPTH  = 2 ** SEQ_AW;
  localparam int DUR_PW = $clog2((2 ** DUR_W) * TICK_CYCLES);
  // Lowest note has the longest half-period.
  localparam int HP_W   = $clog2(CLK_HZ / (2 * note_freq_hz(P_C4)) + 1);

  // --------------------------------------------------------------------------
  // Elaboration-time half-period table and parameter checks
  // --------------------------------------------------------------------------
  logic [HP_W-1:0] hp_tab [16];

  for (genvar c = 0; c < 16; c++) begin : g_hp
    localparam int HP = half_period(CLK_HZ, 4'(c));
    if (HP != 0 && HP < 2) begin : g_hp_too_small
      $error("melody_sequencer: half-period below 2 for pitch code %0d", c);
    end
    assign hp_tab[c] = HP_W'(HP);
  end

  if (GAP_CYCLES >= TICK_CYCLES) begin : g_gap_check
    $error("melody_sequencer: GAP_CYCLES must be smaller than TICK_CYCLES");
  end

  // --------------------------------------------------------------------------
  // Sequence RAM. The read register only loads during FETCH, so it doubles as
  // the latched word for the whole PLAY phase. Read-first on collision.
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] cur_word;
  state_t            state, state_n;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (state == S_FETCH) cur_word <= mem[note_idx];
  end

  logic [PITCH_W-1:0] cur_pitch;
  logic [DUR_W-1:0]   cur_dur;
  assign cur_pitch = cur_word[DUR_W +: PITCH_W];
  assign cur_dur   = cur_word[DUR_W-1:0];

  // --------------------------------------------------------------------------
  // Duration bookkeeping
  // --------------------------------------------------------------------------
  logic [DUR_PW-1:0] dur_cnt, dur_n, dur_units, note_last;
  logic              gap_hit;

  assign dur_units = DUR_PW'({1'b0, cur_dur} + (DUR_W+1)'(1));
  assign note_last = dur_units * DUR_PW'(TICK_CYCLES) - DUR_PW'(1);
  // Asserted one cycle ahead of the gap so the registered output is already
  // silent on the first gap cycle. note_last >= TICK_CYCLES-1 >= GAP_CYCLES.
  assign gap_hit   = (dur_cnt >= note_last - DUR_PW'(GAP_CYCLES));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  logic [SEQ_AW-1:0] idx_n;
  logic [SEQ_AW:0]   len, len_n;
  logic              done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      note_idx <= '0;
      len      <= '0;
      dur_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      note_idx <= idx_n;
      len      <= len_n;
      dur_cnt  <= dur_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = note_idx;
    len_n   = len;
    dur_n   = dur_cnt;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        idx_n = '0;
        dur_n = '0;
        if (start && !stop && seq_len != '0) begin
          len_n   = seq_len;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        dur_n   = '0;
        state_n = S_PLAY;
      end
      S_PLAY: begin
        if (dur_cnt == note_last) begin
          dur_n = '0;
          if (({1'b0, note_idx} + (SEQ_AW+1)'(1)) < len) begin
            idx_n   = note_idx + SEQ_AW'(1);
            state_n = S_FETCH;
          end else if (loop_en) begin
            idx_n   = '0;
            state_n = S_FETCH;
          end else begin
            idx_n   = '0;
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          dur_n = dur_cnt + DUR_PW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort wins over start and over end-of-note.
    if (stop && state != S_IDLE) begin
      state_n = S_IDLE;
      idx_n   = '0;
      dur_n   = '0;
      done_n  = 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Tone output. Cleared on entry to PLAY, on every exit from PLAY, for rest
  // codes and through the articulation gap.
  // --------------------------------------------------------------------------
  logic tone_clr;
  assign tone_clr = (state != S_PLAY) || (state_n != S_PLAY) ||
                    is_rest(cur_pitch) || gap_hit;

  tone_gen #(
    .HP_W (HP_W)
  ) u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == S_PLAY),
    .clr         (tone_clr),
    .half_period (hp_tab[cur_pitch]),
    .wave        (speaker)
  );

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Self-checking bench for melody_sequencer. Two instances share
//               the stimulus: one without and one with an articulation gap.
//               Expected notes are queued when a tune is started or a word is
//               rewritten, then popped and checked cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int CLK_HZ = 26400;
  localparam int TICK   = 200;
  localparam int SEQ_AW = 5;
  localparam int DUR_W  = 3;
  localparam int GAP_G  = 50;

  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, loop_en = 1'b0;
  logic start = 1'b0, stop = 1'b0;
  logic [SEQ_AW-1:0]  wr_addr = '0;
  logic [3+DUR_W:0]   wr_data = '0;
  logic [SEQ_AW:0]    seq_len = '0;
  logic               speaker, busy, done, speaker_g, busy_g, done_g;
  logic [SEQ_AW-1:0]  note_idx, note_idx_g;

  always #5 clk = ~clk;

  melody_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK), .SEQ_AW(SEQ_AW), .DUR_W(DUR_W), .GAP_CYCLES(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .loop_en(loop_en), .start(start), .stop(stop),
    .speaker(speaker), .busy(busy), .note_idx(note_idx), .done(done)
  );

  melody_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK), .SEQ_AW(SEQ_AW), .DUR_W(DUR_W), .GAP_CYCLES(GAP_G)
  ) dut_g (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .loop_en(loop_en), .start(start), .stop(stop),
    .speaker(speaker_g), .busy(busy_g), .note_idx(note_idx_g), .done(done_g)
  );

  typedef struct {
    int idx;
    int hp;    // 0 = rest
    int ncyc;
  } note_t;

  note_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int idx, input int hp, input int ncyc);
    note_t n;
    n.idx = idx; n.hp = hp; n.ncyc = ncyc;
    sb.push_back(n);
  endfunction

  function automatic int exp_spk(input note_t n, input int k, input int gap);
    if (n.hp == 0 || k >= n.ncyc - gap) return 0;
    return (k / n.hp) % 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [3:0] p, input logic [DUR_W-1:0] d);
    wr_en = 1'b1; wr_addr = SEQ_AW'(addr); wr_data = {p, d};
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_seq();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Pops one expected note, checks its FETCH cycle and up to 'limit' PLAY
  // cycles. act 1 clears loop_en at cycle act_k, act 2 rewrites word 1 to E4.
  task automatic run_note(input int limit, input int act_k, input int act);
    note_t n;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("FAIL sb_underflow: observed 0 expected 1");
      return;
    end
    n = sb.pop_front();
    chk("fetch_spk",  int'(speaker),  0);
    chk("fetch_busy", int'(busy),     1);
    chk("fetch_idx",  int'(note_idx), n.idx);
    chk("fetch_done", int'(done),     0);
    step();
    for (int k = 0; k < n.ncyc && k < limit; k++) begin
      wr_en = 1'b0;
      if (k == act_k) begin
        if (act == 1) loop_en = 1'b0;
        else if (act == 2) begin
          wr_en = 1'b1; wr_addr = SEQ_AW'(1); wr_data = {P_E4, 3'd0};
          push(1, 40, TICK);
        end
      end
      chk("spk",      int'(speaker),   exp_spk(n, k, 0));
      chk("spk_gap",  int'(speaker_g), exp_spk(n, k, GAP_G));
      chk("play_idx", int'(note_idx),  n.idx);
      chk("play_busy", int'(busy),     1);
      chk("play_done", int'(done),     0);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic end_done();
    chk("end_done",   int'(done),     1);
    chk("end_done_g", int'(done_g),   1);
    chk("end_busy",   int'(busy),     0);
    chk("end_spk",    int'(speaker),  0);
    chk("end_idx",    int'(note_idx), 0);
    step();
    chk("done_pulse", int'(done),     0);
    chk("done_pulse_g", int'(done_g), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_spk",  int'(speaker),  0);
    chk("rst_busy", int'(busy),     0);
    chk("rst_idx",  int'(note_idx), 0);
    chk("rst_done", int'(done),     0);
    chk("rst_spk_g", int'(speaker_g), 0);
    #10 rst_n = 1'b1;
    step();

    // Zero-length start is ignored
    seq_len = '0;
    start_seq();
    chk("len0_busy", int'(busy), 0);

    // Single note A4, dur=1 -> 400 cycles
    wr(0, P_A4, 3'd1);
    seq_len = 1; loop_en = 1'b0;
    push(0, 30, 2 * TICK);
    start_seq();
    run_note(1000, -1, 0);
    end_done();

    // C5, rest, A4
    wr(0, P_C5, 3'd0);
    wr(1, P_REST, 3'd0);
    wr(2, P_A4, 3'd0);
    seq_len = 3;
    push(0, 25, TICK); push(1, 0, TICK); push(2, 30, TICK);
    start_seq();
    for (int i = 0; i < 3; i++) run_note(1000, -1, 0);
    end_done();

    // Loop once, then drop loop_en during word 1 of the second pass
    loop_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push(0, 25, TICK); push(1, 0, TICK); push(2, 30, TICK);
    end
    start_seq();
    for (int i = 0; i < 6; i++) run_note(1000, (i == 4) ? 100 : -1, 1);
    end_done();

    // Gap: single A4 word, dur 0
    wr(0, P_A4, 3'd0);
    seq_len = 1;
    push(0, 30, TICK);
    start_seq();
    run_note(1000, -1, 0);
    end_done();

    // Stop at cycle 100 with a simultaneous start
    push(0, 30, TICK);
    start_seq();
    run_note(100, -1, 0);
    chk("pre_stop_spk", int'(speaker), 1);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stop_busy", int'(busy),     0);
    chk("stop_spk",  int'(speaker),  0);
    chk("stop_spk_g", int'(speaker_g), 0);
    chk("stop_idx",  int'(note_idx), 0);
    chk("stop_done", int'(done),     0);
    step();
    chk("stop_busy2", int'(busy), 0);
    chk("stop_done2", int'(done), 0);

    // Asynchronous reset mid-PLAY of word 1
    wr(1, P_C5, 3'd0);
    seq_len = 2;
    push(0, 30, TICK); push(1, 25, TICK);
    start_seq();
    run_note(1000, -1, 0);
    run_note(30, -1, 0);
    chk("pre_rst_spk", int'(speaker),  1);
    chk("pre_rst_idx", int'(note_idx), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_spk",  int'(speaker),   0);
    chk("arst_spk_g", int'(speaker_g), 0);
    chk("arst_busy", int'(busy),      0);
    chk("arst_idx",  int'(note_idx),  0);
    chk("arst_busy_g", int'(busy_g),  0);
    chk("arst_idx_g", int'(note_idx_g), 0);
    #1 rst_n = 1'b1;
    step();

    // Live rewrite of word 1 while word 0 plays
    push(0, 30, TICK);
    start_seq();
    run_note(1000, 50, 2);
    run_note(1000, -1, 0);
    end_done();

    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
